// File: rtl/logical_tile_io_input_sync_mode_io_input_.sv
// Multi-channel input-pad tile: per-channel invert, synchroniser, glitch filter,
// edge detect, output select and sticky edge flag. Pads are observed, never driven.
module logical_tile_io_input_sync_mode_io_input_ #(
  parameter int NUM_PADS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  inout  wire  [NUM_PADS-1:0]     gfpga_pad_GPIN_PAD,
  input  logic [NUM_PADS-1:0]     cfg_invert,
  input  logic [NUM_PADS-1:0]     cfg_filter_en,
  input  logic [2*NUM_PADS-1:0]   cfg_mode,
  input  logic [NUM_PADS-1:0]     event_clr,
  output logic [NUM_PADS-1:0]     io_input_inpad,
  output logic [NUM_PADS-1:0]     io_input_event
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    MODE_RAW  = 2'b00,
    MODE_FILT = 2'b01,
    MODE_RISE = 2'b10,
    MODE_FALL = 2'b11
  } mode_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_ch
      logic                   w_x;
      logic                   w_s;
      logic                   w_rise;
      logic                   w_fall;
      logic                   w_out;
      mode_t                  w_mode;
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_filt;
      logic                   r_prev;
      logic                   r_event;
      logic [CNT_W-1:0]       r_cnt;

      assign w_x    = gfpga_pad_GPIN_PAD[gi] ^ cfg_invert[gi];
      assign w_s    = r_sync[SYNC_STAGES-1];
      assign w_mode = mode_t'(cfg_mode[2*gi +: 2]);

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_x};
        end
      end

      // A disagreement must persist FILTER_LEN samples; any agreeing sample restarts it.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_filt <= 1'b0;
          r_cnt  <= '0;
        end else if (!cfg_filter_en[gi]) begin
          r_filt <= w_s;
          r_cnt  <= '0;
        end else if (w_s == r_filt) begin
          r_cnt  <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_filt <= w_s;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
        end
      end

      assign w_rise = r_filt & ~r_prev;
      assign w_fall = ~r_filt & r_prev;

      // Set wins over a simultaneous clear so no edge is ever lost.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_prev  <= 1'b0;
          r_event <= 1'b0;
        end else begin
          r_prev  <= r_filt;
          r_event <= (r_event & ~event_clr[gi]) | w_rise | w_fall;
        end
      end

      always_comb begin
        w_out = 1'b0;
        case (w_mode)
          MODE_RAW:  w_out = w_x;
          MODE_FILT: w_out = r_filt;
          MODE_RISE: w_out = w_rise;
          MODE_FALL: w_out = w_fall;
          default:   w_out = 1'b0;
        endcase
      end

      assign io_input_inpad[gi] = w_out;
      assign io_input_event[gi] = r_event;
    end
  endgenerate

endmodule

// File: tb/tb_logical_tile_io_input_sync_mode_io_input_.sv
// Directed self-checking bench for the input-pad tile, default parameters
// (4 pads, 2 sync stages, filter length 4).
module tb_logical_tile_io_input_sync_mode_io_input_;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pad_drv;
  wire  [3:0] pad;
  logic [3:0] cfg_invert;
  logic [3:0] cfg_filter_en;
  logic [7:0] cfg_mode;
  logic [3:0] event_clr;
  logic [3:0] io_input_inpad;
  logic [3:0] io_input_event;

  int n_vec = 0;
  int n_err = 0;

  assign pad = pad_drv;

  logical_tile_io_input_sync_mode_io_input_ #(
    .NUM_PADS(4), .SYNC_STAGES(2), .FILTER_LEN(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .gfpga_pad_GPIN_PAD(pad),
    .cfg_invert        (cfg_invert),
    .cfg_filter_en     (cfg_filter_en),
    .cfg_mode          (cfg_mode),
    .event_clr         (event_clr),
    .io_input_inpad    (io_input_inpad),
    .io_input_event    (io_input_event)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [1:0] mm;
    reset = 1'b1; pad_drv = 4'b0000; cfg_invert = 4'b0000;
    cfg_filter_en = 4'b0101; cfg_mode = 8'b01_01_01_01; event_clr = 4'b0000;
    step(3);
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      cfg_mode = {4{mm}};
      #1;
      n_vec++;
      if (io_input_inpad !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_out mode=%0d got=%b want=0000", m, io_input_inpad);
      end
    end
    n_vec++;
    if (io_input_event !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_event got=%b want=0000", io_input_event);
    end
    cfg_mode = 8'b01_01_01_00;
    pad_drv[0] = 1'b1;
    #1;
    n_vec++;
    if (io_input_inpad[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_bypass_hi got=%b want=1", io_input_inpad[0]);
    end
    pad_drv[0] = 1'b0;
    #1;
    n_vec++;
    if (io_input_inpad[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_bypass_lo got=%b want=0", io_input_inpad[0]);
    end
    reset = 1'b0;
    cfg_mode = 8'b01_10_01_01;
    step(2);
    $display("test_reset done, miscompares so far %0d", n_err);
  endtask

  task automatic test_filter_latency;
    logic exp;
    pad_drv[0] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      step(1);
      exp = (j >= 5);
      n_vec++;
      if (io_input_inpad[0] !== exp) begin
        n_err++;
        $display("FAIL filt_rise edge=k+%0d got=%b want=%b", j, io_input_inpad[0], exp);
      end
    end
    pad_drv[0] = 1'b0;
    for (int j = 0; j < 7; j++) begin
      step(1);
      exp = (j < 5);
      n_vec++;
      if (io_input_inpad[0] !== exp) begin
        n_err++;
        $display("FAIL filt_fall edge=k+%0d got=%b want=%b", j, io_input_inpad[0], exp);
      end
    end
    step(3);
    // Two 3-cycle glitches back to back: both must be rejected.
    for (int p = 0; p < 2; p++) begin
      pad_drv[0] = 1'b1;
      for (int j = 0; j < 13; j++) begin
        step(1);
        if (j == 2) pad_drv[0] = 1'b0;
        n_vec++;
        if (io_input_inpad[0] !== 1'b0) begin
          n_err++;
          $display("FAIL filt_glitch pulse=%0d edge=k+%0d got=%b want=0", p, j, io_input_inpad[0]);
        end
      end
    end
    // A 4-cycle pulse is just long enough to pass.
    pad_drv[0] = 1'b1;
    for (int j = 0; j < 13; j++) begin
      step(1);
      if (j == 3) pad_drv[0] = 1'b0;
      exp = (j >= 5 && j < 9);
      n_vec++;
      if (io_input_inpad[0] !== exp) begin
        n_err++;
        $display("FAIL filt_min_pulse edge=k+%0d got=%b want=%b", j, io_input_inpad[0], exp);
      end
    end
    step(3);
    $display("test_filter_latency done, miscompares so far %0d", n_err);
  endtask

  task automatic test_filter_disabled;
    logic exp;
    pad_drv[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step(1);
      exp = (j >= 2);
      n_vec++;
      if (io_input_inpad[1] !== exp) begin
        n_err++;
        $display("FAIL nofilt_rise edge=k+%0d got=%b want=%b", j, io_input_inpad[1], exp);
      end
    end
    cfg_invert[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step(1);
      exp = (j < 2);
      n_vec++;
      if (io_input_inpad[1] !== exp) begin
        n_err++;
        $display("FAIL nofilt_invert edge=k+%0d got=%b want=%b", j, io_input_inpad[1], exp);
      end
    end
    cfg_invert[1] = 1'b0;
    step(4);
    n_vec++;
    if (io_input_inpad[1] !== 1'b1) begin
      n_err++;
      $display("FAIL nofilt_uninvert got=%b want=1", io_input_inpad[1]);
    end
    pad_drv[1] = 1'b0;
    step(4);
    n_vec++;
    if (io_input_inpad[1] !== 1'b0) begin
      n_err++;
      $display("FAIL nofilt_low got=%b want=0", io_input_inpad[1]);
    end
    $display("test_filter_disabled done, miscompares so far %0d", n_err);
  endtask

  task automatic test_edge_modes;
    int cnt;
    int pos;
    logic [1:0] lvl_seq [4];
    logic [1:0] mode_seq [4];
    int want_cnt [4];
    lvl_seq  = '{2'd1, 2'd0, 2'd1, 2'd0};
    mode_seq = '{2'b10, 2'b10, 2'b11, 2'b11};
    want_cnt = '{1, 0, 0, 1};
    for (int ph = 0; ph < 4; ph++) begin
      cfg_mode[5:4] = mode_seq[ph];
      pad_drv[2] = lvl_seq[ph][0];
      cnt = 0;
      pos = -1;
      for (int j = 0; j < 10; j++) begin
        step(1);
        if (io_input_inpad[2] === 1'b1) begin
          cnt++;
          if (pos < 0) pos = j;
        end
      end
      n_vec++;
      if (cnt !== want_cnt[ph]) begin
        n_err++;
        $display("FAIL edge_count phase=%0d got=%0d want=%0d", ph, cnt, want_cnt[ph]);
      end
      if (want_cnt[ph] == 1) begin
        n_vec++;
        if (pos !== 5) begin
          n_err++;
          $display("FAIL edge_pos phase=%0d got=k+%0d want=k+5", ph, pos);
        end
      end
    end
    $display("test_edge_modes done, miscompares so far %0d", n_err);
  endtask

  task automatic test_sticky;
    logic exp;
    n_vec++;
    if (io_input_event[3] !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_init got=%b want=0", io_input_event[3]);
    end
    pad_drv[3] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step(1);
      exp = (j >= 3);
      n_vec++;
      if (io_input_event[3] !== exp) begin
        n_err++;
        $display("FAIL sticky_set edge=k+%0d got=%b want=%b", j, io_input_event[3], exp);
      end
    end
    step(5);
    n_vec++;
    if (io_input_event[3] !== 1'b1) begin
      n_err++;
      $display("FAIL sticky_hold got=%b want=1", io_input_event[3]);
    end
    event_clr[3] = 1'b1;
    step(1);
    event_clr[3] = 1'b0;
    n_vec++;
    if (io_input_event[3] !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_clear got=%b want=0", io_input_event[3]);
    end
    step(2);
    n_vec++;
    if (io_input_event[3] !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_stay_clear got=%b want=0", io_input_event[3]);
    end
    event_clr[3] = 1'b1;
    pad_drv[3] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step(1);
      exp = (j == 3);
      n_vec++;
      if (io_input_event[3] !== exp) begin
        n_err++;
        $display("FAIL sticky_collision edge=k+%0d got=%b want=%b", j, io_input_event[3], exp);
      end
    end
    event_clr[3] = 1'b0;
    $display("test_sticky done, miscompares so far %0d", n_err);
  endtask

  task automatic test_reset_mid_count;
    logic exp_out;
    logic exp_evt;
    pad_drv[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step(1);
      n_vec++;
      if (io_input_inpad[0] !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_pre edge=k+%0d got=%b want=0", j, io_input_inpad[0]);
      end
    end
    reset = 1'b1;
    step(2);
    n_vec++;
    if (io_input_inpad[0] !== 1'b0 || io_input_event !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_during out=%b evt=%b want out=0 evt=0000", io_input_inpad[0], io_input_event);
    end
    reset = 1'b0;
    for (int j = 0; j < 7; j++) begin
      step(1);
      exp_out = (j >= 5);
      exp_evt = (j >= 6);
      n_vec++;
      if (io_input_inpad[0] !== exp_out || io_input_event[0] !== exp_evt) begin
        n_err++;
        $display("FAIL midrst_release edge=m+%0d out=%b evt=%b want out=%b evt=%b",
                 j, io_input_inpad[0], io_input_event[0], exp_out, exp_evt);
      end
    end
    $display("test_reset_mid_count done, miscompares so far %0d", n_err);
  endtask

  initial begin
    test_reset();
    test_filter_latency();
    test_filter_disabled();
    test_edge_modes();
    test_sticky();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
